// File: rtl/farm_scan_scheduler.sv
// ---------------------------------------------------------------------------
// farm_scan_scheduler
//   Round-robin scheduler for the shared 8-bit sensor pin bus. It visits each
//   enabled channel, waits for the analog mux to settle, captures a burst of
//   samples and hands them to the datapath over valid/ready. An active camera
//   frame pre-empts scanning; a pending sample is always handed off first.
//
//   Optional feature macro: SCHED_TIMEOUT_EN
//     defined   - a sample stalled for 255 cycles is dropped, timeout_err set
//     undefined - smp_valid waits indefinitely, timeout_err stays 0
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       scan enable
//   ch_mask      per-channel enable (bit i = channel i)
//   cam_frame    camera frame active, requests the pin bus
//   pin_data     shared sensor/pixel input bus
//   sensor_sel   external analog mux select
//   smp_valid / smp_ready / smp_data / smp_ch   sample handshake to datapath
//   cam_grant    pin bus granted to camera path
//   scan_done    one-cycle pulse after the final accept of a full pass
//   busy         scheduler not idle
//   timeout_err  sticky handshake timeout flag
// ---------------------------------------------------------------------------
module farm_scan_scheduler #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned SETTLE_CYC     = 8,
   parameter int unsigned SAMPLES_PER_CH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [NUM_CH-1:0]         ch_mask,
   input  logic                      cam_frame,
   input  logic [7:0]                pin_data,
   output logic [$clog2(NUM_CH)-1:0] sensor_sel,
   output logic                      smp_valid,
   input  logic                      smp_ready,
   output logic [7:0]                smp_data,
   output logic [$clog2(NUM_CH)-1:0] smp_ch,
   output logic                      cam_grant,
   output logic                      scan_done,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned SET_W = 4;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_CAM
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_W-1:0]   sel_d, smp_ch_d;
   logic [7:0]        smp_data_d;
   logic              smp_valid_d, scan_done_d, timeout_err_d;

   logic [CH_W-1:0]   pick_ch_c, pick_idx_c, hi_ch_c;
   logic              pick_found_c;
   logic [CNT_W:0]    cnt_inc_c;
   logic              last_c, accept_c, tmo_hit_c;

   // Next enabled channel strictly after the pointer, wrapping; the pointer
   // itself is the last candidate. Descending loop lets the nearest win.
   always_comb begin
      pick_found_c = 1'b0;
      pick_ch_c    = ptr_q;
      pick_idx_c   = ptr_q;
      for (int i = NUM_CH; i >= 1; i--) begin
         pick_idx_c = ptr_q + CH_W'(i);
         if (ch_mask[pick_idx_c]) begin
            pick_found_c = 1'b1;
            pick_ch_c    = pick_idx_c;
         end
      end
   end

   // Highest enabled channel marks the end of a pass.
   always_comb begin
      hi_ch_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_mask[i]) hi_ch_c = CH_W'(i);
      end
   end

   assign cnt_inc_c = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign last_c    = (cnt_inc_c == (CNT_W+1)'(SAMPLES_PER_CH));
   assign accept_c  = smp_valid && (smp_ready || tmo_hit_c);

`ifdef SCHED_TIMEOUT_EN
   logic [7:0] tmo_q, tmo_d;
   logic       stall_c;

   // Stall counter; hit on the 255th consecutive stalled cycle.
   assign stall_c   = smp_valid && !smp_ready;
   assign tmo_hit_c = stall_c && (tmo_q == 8'd254);

   always_comb begin
      tmo_d = 8'd0;
      if (stall_c && !tmo_hit_c) tmo_d = tmo_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= 8'd0;
      else        tmo_q <= tmo_d;
   end
`else
   assign tmo_hit_c = 1'b0;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      settle_d      = settle_q;
      cnt_d         = cnt_q;
      sel_d         = sensor_sel;
      smp_valid_d   = smp_valid;
      smp_data_d    = smp_data;
      smp_ch_d      = smp_ch;
      scan_done_d   = 1'b0;
      timeout_err_d = timeout_err || tmo_hit_c;

      case (state_q)
         S_IDLE: begin
            if (cam_frame)                  state_d = S_CAM;
            else if (enable && |ch_mask)    state_d = S_SELECT;
         end
         S_SELECT: begin
            if (cam_frame) begin
               state_d = S_CAM;
            end else if (!enable || !pick_found_c) begin
               state_d = S_IDLE;
            end else begin
               sel_d    = pick_ch_c;
               settle_d = '0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cam_frame)                                  state_d = S_CAM;
            else if (!enable)                               state_d = S_IDLE;
            else if (settle_q == SET_W'(SETTLE_CYC - 1))    state_d = S_SAMPLE;
            else                                            settle_d = settle_q + SET_W'(1);
         end
         S_SAMPLE: begin
            if (smp_valid) begin
               // Held sample leaves only through an accept (or timeout drop).
               if (accept_c) begin
                  smp_valid_d = 1'b0;
                  if (last_c) begin
                     cnt_d       = '0;
                     ptr_d       = sensor_sel;
                     scan_done_d = (sensor_sel == hi_ch_c);
                     state_d     = cam_frame ? S_CAM : S_SELECT;
                  end else begin
                     cnt_d = cnt_inc_c[CNT_W-1:0];
                  end
               end
            end else if (cam_frame) begin
               state_d = S_CAM;
            end else if (!enable) begin
               state_d = S_IDLE;
            end else begin
               smp_valid_d = 1'b1;
               smp_data_d  = pin_data;
               smp_ch_d    = sensor_sel;
            end
         end
         S_CAM: begin
            if (!cam_frame) state_d = S_SELECT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= CH_W'(NUM_CH - 1);
         settle_q    <= '0;
         cnt_q       <= '0;
         sensor_sel  <= '0;
         smp_valid   <= 1'b0;
         smp_data    <= 8'd0;
         smp_ch      <= '0;
         cam_grant   <= 1'b0;
         scan_done   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         settle_q    <= settle_d;
         cnt_q       <= cnt_d;
         sensor_sel  <= sel_d;
         smp_valid   <= smp_valid_d;
         smp_data    <= smp_data_d;
         smp_ch      <= smp_ch_d;
         cam_grant   <= (state_d == S_CAM);
         scan_done   <= scan_done_d;
         busy        <= (state_d != S_IDLE);
         timeout_err <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_farm_scan_scheduler.sv
// Bench for farm_scan_scheduler: scoreboard of expected (channel, data)
// pairs, popped by a monitor on every accepted sample.
module tb_farm_scan_scheduler;

   localparam int unsigned SETTLE_CYC = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] ch_mask = 4'b0000;
   logic       cam_frame = 1'b0;
   logic [7:0] pin_data;
   logic [1:0] sensor_sel;
   logic       smp_valid;
   logic       smp_ready = 1'b0;
   logic [7:0] smp_data;
   logic [1:0] smp_ch;
   logic       cam_grant, scan_done, busy, timeout_err;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   acc_cnt = 0;
   int   done_cnt = 0;
   int   done_at = 0;
   int   stall_run = 0;
   bit   prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic [1:0] prev_ch;
   bit   sel_seen [4];

   always #5 clk = ~clk;

   // Sensor model: each channel presents its own fixed level on the pin bus.
   assign pin_data = 8'h64 + {2'b00, sensor_sel, 4'h0};

   function automatic logic [7:0] level_of(input logic [1:0] ch);
      logic [7:0] lv [4];
      lv[0] = 8'h64; lv[1] = 8'h74; lv[2] = 8'h84; lv[3] = 8'h94;
      return lv[ch];
   endfunction

   farm_scan_scheduler #(.NUM_CH(4), .SETTLE_CYC(SETTLE_CYC), .SAMPLES_PER_CH(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
      .cam_frame(cam_frame), .pin_data(pin_data), .sensor_sel(sensor_sel),
      .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
      .smp_ch(smp_ch), .cam_grant(cam_grant), .scan_done(scan_done),
      .busy(busy), .timeout_err(timeout_err)
   );

   // Monitor: scoreboard pops on accept, hold-stability while stalled.
   always @(negedge clk) begin
      exp_t e;
      bit   exempt;
      if (!rst_n) begin
         prev_stall = 1'b0;
         stall_run  = 0;
      end else begin
         exempt = 1'b0;
`ifdef SCHED_TIMEOUT_EN
         exempt = (stall_run >= 255);
`endif
         if (prev_stall && !exempt) begin
            checks++;
            if (!(smp_valid === 1'b1 && smp_data === prev_data && smp_ch === prev_ch)) begin
               errors++;
               $display("FAIL hold_stable: valid=%b data=%h ch=%0d, required valid=1 data=%h ch=%0d",
                        smp_valid, smp_data, smp_ch, prev_data, prev_ch);
            end
         end
         if (smp_valid && smp_ready) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_sample: ch=%0d data=%h, required none", smp_ch, smp_data);
            end else begin
               e = exp_q.pop_front();
               if (smp_ch !== e.ch || smp_data !== e.data) begin
                  errors++;
                  $display("FAIL sample: ch=%0d data=%h, required ch=%0d data=%h",
                           smp_ch, smp_data, e.ch, e.data);
               end
            end
         end
         if (scan_done) begin
            done_cnt++;
            done_at = acc_cnt;
         end
         if (busy) sel_seen[sensor_sel] = 1'b1;
         if (smp_valid && !smp_ready) stall_run++;
         else                         stall_run = 0;
         prev_stall = smp_valid && !smp_ready;
         prev_data  = smp_data;
         prev_ch    = smp_ch;
      end
   end

   task automatic push_exp(input logic [1:0] ch, input int n);
      exp_t e;
      e.ch   = ch;
      e.data = level_of(ch);
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic clear_stats();
      acc_cnt  = 0;
      done_cnt = 0;
      done_at  = 0;
      for (int i = 0; i < 4; i++) sel_seen[i] = 1'b0;
   endtask

   task automatic wait_acc(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (acc_cnt >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_valid(input int budget, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         n++;
         if (smp_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic go_idle();
      enable = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL idle_drain: busy=%b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      checks++;
      if ({sensor_sel, smp_valid, smp_data, smp_ch, cam_grant, scan_done, busy, timeout_err} !== 16'h0) begin
         errors++;
         $display("FAIL %s: sel=%0d valid=%b data=%h ch=%0d grant=%b done=%b busy=%b terr=%b, required all 0",
                  tag, sensor_sel, smp_valid, smp_data, smp_ch, cam_grant, scan_done, busy, timeout_err);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset_values");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("idle_after_reset");
   endtask

   task automatic test_full_scan();
      int n; bit ok;
      clear_stats();
      ch_mask = 4'b1111; smp_ready = 1'b1;
      for (int c = 0; c < 4; c++) push_exp(2'(c), 4);
      @(posedge clk); #2;
      enable = 1'b1;
      wait_valid(100, n, ok);
      checks++;
      if (!ok || n - 1 != SETTLE_CYC + 2) begin
         errors++;
         $display("FAIL first_latency: %0d cycles, required %0d", n - 1, SETTLE_CYC + 2);
      end
      wait_acc(16, 200, ok);
      enable = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL full_scan_timeout: accepts=%0d, required 16", acc_cnt); end
      @(posedge clk); #2;
      checks++;
      if (done_cnt != 1 || done_at != 16) begin
         errors++;
         $display("FAIL scan_done_pulse: pulses=%0d at accept %0d, required 1 at 16", done_cnt, done_at);
      end
      go_idle();
   endtask

   task automatic test_mask_1010();
      bit ok;
      clear_stats();
      ch_mask = 4'b1010; smp_ready = 1'b1;
      push_exp(2'd1, 4); push_exp(2'd3, 4);
      enable = 1'b1;
      wait_acc(8, 200, ok);
      enable = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL mask_timeout: accepts=%0d, required 8", acc_cnt); end
      @(posedge clk); #2;
      checks++;
      if (sel_seen[0] || sel_seen[2]) begin
         errors++;
         $display("FAIL mask_sel: saw sel0=%b sel2=%b, required both 0", sel_seen[0], sel_seen[2]);
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL mask_done: pulses=%0d, required 1", done_cnt); end
      go_idle();
   endtask

   task automatic test_cam_preempt();
      int n; bit ok;
      clear_stats();
      ch_mask = 4'b1111; smp_ready = 1'b1;
      for (int c = 0; c < 4; c++) push_exp(2'(c), 4);
      enable = 1'b1;
      wait_acc(8, 200, ok);
      repeat (3) @(posedge clk);
      #1;
      cam_frame = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cam_grant !== 1'b1 || smp_valid !== 1'b0 || sensor_sel !== 2'd2 || acc_cnt != 8) begin
         errors++;
         $display("FAIL cam_enter: grant=%b valid=%b sel=%0d acc=%0d, required 1 0 2 8",
                  cam_grant, smp_valid, sensor_sel, acc_cnt);
      end
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (cam_grant !== 1'b1 || sensor_sel !== 2'd2) begin
            errors++;
            $display("FAIL cam_hold: grant=%b sel=%0d, required 1 2", cam_grant, sensor_sel);
         end
      end
      cam_frame = 1'b0;
      wait_valid(100, n, ok);
      checks++;
      if (!ok || n - 1 != SETTLE_CYC + 2 || smp_ch !== 2'd2) begin
         errors++;
         $display("FAIL cam_resume: %0d cycles ch=%0d, required %0d ch=2", n - 1, smp_ch, SETTLE_CYC + 2);
      end
      wait_acc(16, 200, ok);
      enable = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL cam_scan_timeout: accepts=%0d, required 16", acc_cnt); end
      go_idle();
   endtask

   task automatic test_stall_cam();
      int n; bit ok;
      clear_stats();
      ch_mask = 4'b0001; smp_ready = 1'b0;
      push_exp(2'd0, 4);
      enable = 1'b1;
      wait_valid(100, n, ok);
      for (int k = 0; k < 20; k++) begin
         if (k == 5) cam_frame = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (cam_grant !== 1'b0 || smp_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_cam: grant=%b valid=%b, required 0 1", cam_grant, smp_valid);
         end
      end
      smp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (acc_cnt != 1 || smp_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_accept: acc=%0d valid=%b, required 1 0", acc_cnt, smp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (cam_grant !== 1'b1 || smp_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_then_cam: grant=%b valid=%b, required 1 0", cam_grant, smp_valid);
      end
      cam_frame = 1'b0;
      wait_acc(4, 200, ok);
      enable = 1'b0;
      checks++;
      if (!ok || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL stall_finish: acc=%0d terr=%b, required 4 0", acc_cnt, timeout_err);
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      int n; bit ok;
      clear_stats();
      ch_mask = 4'b1111; smp_ready = 1'b0;
      enable = 1'b1;
      wait_valid(100, n, ok);
      checks++;
      if (!ok || smp_ch !== 2'd1) begin
         errors++;
         $display("FAIL pre_reset_ch: ch=%0d, required 1", smp_ch);
      end
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      @(negedge clk) rst_n = 1'b1;
      push_exp(2'd0, 4);
      smp_ready = 1'b1;
      wait_acc(4, 200, ok);
      enable = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL restart_timeout: accepts=%0d, required 4", acc_cnt); end
      go_idle();
   endtask

`ifdef SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n, k; bit ok;
      clear_stats();
      ch_mask = 4'b0001; smp_ready = 1'b0;
      push_exp(2'd0, 3);
      enable = 1'b1;
      wait_valid(100, n, ok);
      k = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         k++;
         if (!smp_valid) break;
      end
      checks++;
      if (k != 255 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_drop: %0d cycles terr=%b, required 255 1", k, timeout_err);
      end
      smp_ready = 1'b1;
      wait_acc(3, 200, ok);
      enable = 1'b0;
      checks++;
      if (!ok || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_continue: acc=%0d terr=%b, required 3 1", acc_cnt, timeout_err);
      end
      go_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_full_scan();
      test_mask_1010();
      test_cam_preempt();
      test_stall_cam();
      test_reset_mid();
`ifdef SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
